// File: rtl/myniosiicpu_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : myniosiicpu_led_seq
// Purpose  : Avalon-MM LED pattern sequencer (direct, blink, chase, table).
// Revision : 1.0 - initial release
// ============================================================================
module myniosiicpu_led_seq #(
   parameter int LED_W = 4,
   parameter int CNT_W = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [LED_W-1:0]  out_port
);

   localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
   localparam logic [2:0] c_ADDR_DIRECT = 3'd1;
   localparam logic [2:0] c_ADDR_PERIOD = 3'd2;
   localparam logic [2:0] c_ADDR_STATUS = 3'd3;

   localparam logic [1:0] c_MODE_BLINK = 2'd1;
   localparam logic [1:0] c_MODE_CHASE = 2'd2;
   localparam logic [1:0] c_MODE_TABLE = 2'd3;

   logic [1:0]       r_mode;
   logic             r_run;
   logic [1:0]       r_tbl_last;
   logic [LED_W-1:0] r_direct;
   logic [CNT_W-1:0] r_period;
   logic [LED_W-1:0] r_tbl [4];

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_index;
   logic             r_phase;
   logic [LED_W-1:0] r_chase;

   logic             w_wr;
   logic             w_restart;
   logic             w_running;
   logic             w_tick;
   logic [LED_W-1:0] w_chase_seed;
   logic [LED_W-1:0] w_out_next;
   logic             w_unused_wdata;

   assign w_wr      = chipselect && !write_n;
   assign w_restart = w_wr && ((address == c_ADDR_CTRL) || (address == c_ADDR_DIRECT) ||
                               (address == c_ADDR_PERIOD) ||
                               ((address == c_ADDR_STATUS) && writedata[0]));
   assign w_running = r_run && (r_mode != 2'd0);
   assign w_tick    = w_running && (r_cnt == r_period);

   // The chase seed must be the value being written when DIRECT itself restarts.
   assign w_chase_seed = (w_wr && (address == c_ADDR_DIRECT)) ? writedata[LED_W-1:0] : r_direct;

   assign w_unused_wdata = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode     <= '0;
         r_run      <= 1'b0;
         r_tbl_last <= '0;
         r_direct   <= '0;
         r_period   <= '0;
         for (int i = 0; i < 4; i++) r_tbl[i] <= '0;
      end else if (w_wr) begin
         case (address)
            c_ADDR_CTRL: begin
               r_mode     <= writedata[1:0];
               r_run      <= writedata[2];
               r_tbl_last <= writedata[4:3];
            end
            c_ADDR_DIRECT: r_direct <= writedata[LED_W-1:0];
            c_ADDR_PERIOD: r_period <= writedata[CNT_W-1:0];
            c_ADDR_STATUS: ;
            default:       r_tbl[address[1:0]] <= writedata[LED_W-1:0];
         endcase
      end
   end

   // Restart has priority over a coincident tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_index <= '0;
         r_phase <= 1'b0;
         r_chase <= '0;
      end else if (w_restart) begin
         r_cnt   <= '0;
         r_index <= '0;
         r_phase <= 1'b0;
         r_chase <= w_chase_seed;
      end else if (!w_running) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         if (r_mode == c_MODE_BLINK) r_phase <= ~r_phase;
         if (r_mode == c_MODE_CHASE) r_chase <= {r_chase[LED_W-2:0], r_chase[LED_W-1]};
         if (r_mode == c_MODE_TABLE) r_index <= (r_index == r_tbl_last) ? 2'd0 : r_index + 2'd1;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_out_next = r_direct;
      if (w_running) begin
         case (r_mode)
            c_MODE_BLINK: w_out_next = r_phase ? '0 : r_direct;
            c_MODE_CHASE: w_out_next = r_chase;
            c_MODE_TABLE: w_out_next = r_tbl[r_index];
            default:      w_out_next = r_direct;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_port <= '0;
      else          out_port <= w_out_next;
   end

   always_comb begin
      readdata = '0;
      case (address)
         c_ADDR_CTRL:   readdata[4:0]       = {r_tbl_last, r_run, r_mode};
         c_ADDR_DIRECT: readdata[LED_W-1:0] = r_direct;
         c_ADDR_PERIOD: readdata[CNT_W-1:0] = r_period;
         c_ADDR_STATUS: begin
            readdata[1:0]     = r_index;
            readdata[2]       = w_running;
            readdata[3]       = r_phase;
            readdata[4+:LED_W] = out_port;
         end
         default:       readdata[LED_W-1:0] = r_tbl[address[1:0]];
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_myniosiicpu_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_myniosiicpu_led_seq
// Purpose  : Directed self-checking bench for the LED pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myniosiicpu_led_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [3:0]  out_port;

   int n_checks = 0;
   int n_fail   = 0;

   myniosiicpu_led_seq #(.LED_W(4), .CNT_W(24)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write lands on the next rising edge; returns 1ns after that edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic step_chk(input string tag, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check(tag, {28'd0, out_port}, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [3:0]  tblv [3];
      tblv[0] = 4'h1; tblv[1] = 4'h3; tblv[2] = 4'h7;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", {28'd0, out_port}, 32'h0);
      rd(3'd3, d); check("reset_status", d, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Direct
      wr(3'd1, 32'hA);
      check("direct_pre", {28'd0, out_port}, 32'h0);
      wr(3'd0, 32'h0);
      check("direct_out", {28'd0, out_port}, 32'hA);
      rd(3'd3, d); check("direct_status", d, 32'hA0);
      rd(3'd1, d); check("direct_readback", d, 32'hA);

      // Blink: PERIOD=3 gives four clocks per phase
      wr(3'd2, 32'h3);
      wr(3'd1, 32'h5);
      wr(3'd0, 32'h5);
      check("blink_start", {28'd0, out_port}, 32'h5);
      for (int i = 0; i < 12; i++)
         step_chk($sformatf("blink_%0d", i), (i < 4 || i >= 8) ? 32'h5 : 32'h0);
      rd(3'd3, d); check("blink_running", {31'd0, d[2]}, 32'h1);

      // Chase, one step per clock
      wr(3'd1, 32'h1);
      wr(3'd2, 32'h0);
      wr(3'd0, 32'h6);
      for (int i = 0; i < 6; i++)
         step_chk($sformatf("chase_%0d", i), 32'h1 << (i % 4));
      wr(3'd3, 32'h1);
      check("chase_restart_edge", {28'd0, out_port}, 32'h4);
      step_chk("chase_restart_1", 32'h1);
      step_chk("chase_restart_2", 32'h2);

      // Mid-pattern asynchronous reset
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_out", {28'd0, out_port}, 32'h0);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         check($sformatf("async_reset_reg%0d", a), d, 32'h0);
      end
      @(negedge clk);
      reset_n = 1'b1;

      // Table wrap with tbl_last=2, PERIOD=1
      wr(3'd4, 32'h1);
      wr(3'd5, 32'h3);
      wr(3'd6, 32'h7);
      wr(3'd7, 32'hF);
      wr(3'd2, 32'h1);
      wr(3'd0, 32'h17);
      for (int i = 0; i < 8; i++) begin
         step_chk($sformatf("table_out_%0d", i), {28'd0, tblv[(i/2)%3]});
         rd(3'd3, d);
         check($sformatf("table_idx_%0d", i), {30'd0, d[1:0]}, 32'(((i+1)/2)%3));
      end

      // Tick/restart collision: PERIOD rewritten while cnt == PERIOD
      wr(3'd2, 32'h2);
      wr(3'd0, 32'h1F);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      rd(3'd3, d); check("coll_pre_idx", {30'd0, d[1:0]}, 32'h1);
      wr(3'd2, 32'h2);
      rd(3'd3, d); check("coll_idx", {30'd0, d[1:0]}, 32'h0);
      check("coll_out", {28'd0, out_port}, 32'h3);
      step_chk("coll_out_1", 32'h1);
      step_chk("coll_out_2", 32'h1);
      rd(3'd3, d); check("coll_idx_2", {30'd0, d[1:0]}, 32'h0);
      @(posedge clk);
      #1;
      rd(3'd3, d); check("coll_idx_3", {30'd0, d[1:0]}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
